// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: HI/LO multiply/divide unit.
// Multiplication is radix-2 shift-add and division is restoring division,
// one bit per cycle. Signed operations iterate on operand magnitudes, and a
// single FIX cycle applies the signs before HI/LO are written.
// MTHI/MTLO write a register directly and complete in one cycle.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [5:0] LAST_ITER = 6'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    // Two's-complement negation helpers used for magnitudes and sign fix-up.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        logic signed [31:0] sv;
        sv = $signed(v);
        return $unsigned(-sv);
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        logic signed [63:0] sv;
        sv = $signed(v);
        return $unsigned(-sv);
    endfunction

    // Magnitude of an operand; only negative when the op is signed.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_neg);
        return is_neg ? neg32(v) : v;
    endfunction

    // Architectural and control state
    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Captured operands: magnitudes plus the original sign bits
    logic [31:0] a_mag_q, a_mag_d;
    logic [31:0] b_mag_q, b_mag_d;
    logic        a_neg_q, a_neg_d;
    logic        b_neg_q, b_neg_d;

    // Datapath working registers
    logic [63:0] acc_q, acc_d;   // multiply: {running upper sum, remaining multiplier}
    logic [31:0] rem_q, rem_d;   // divide: partial remainder (always < divisor)
    logic [31:0] quo_q, quo_d;   // divide: dividend bits shifting out, quotient bits in

    // Combinational temporaries
    logic        in_signed;
    logic        in_a_neg;
    logic        in_b_neg;
    logic [32:0] mul_sum;
    logic [32:0] div_part;
    logic [32:0] div_diff;
    logic        div_fits;
    logic        fix_is_mul;
    logic [63:0] fix_prod;

    // Next-state, datapath step and output register computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dbz_d      = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        a_mag_d    = a_mag_q;
        b_mag_d    = b_mag_q;
        a_neg_d    = a_neg_q;
        b_neg_d    = b_neg_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        quo_d      = quo_q;

        in_signed  = (op == OP_MULT) || (op == OP_DIV);
        in_a_neg   = in_signed & a[31];
        in_b_neg   = in_signed & b[31];

        mul_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_mag_q} : 33'd0);

        // The shifted partial remainder needs 33 bits before the trial subtract.
        div_part   = {rem_q, quo_q[31]};
        div_diff   = div_part - {1'b0, b_mag_q};
        div_fits   = (div_part >= {1'b0, b_mag_q});

        fix_is_mul = (op_q == OP_MULT) || (op_q == OP_MULTU);
        fix_prod   = (a_neg_q ^ b_neg_q) ? neg64(acc_q) : acc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            op_d    = op;
                            a_neg_d = in_a_neg;
                            b_neg_d = in_b_neg;
                            a_mag_d = mag32(a, in_a_neg);
                            b_mag_d = mag32(b, in_b_neg);
                            acc_d   = {32'd0, mag32(b, in_b_neg)};
                            cnt_d   = 6'd0;
                            busy_d  = 1'b1;
                            state_d = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (b == 32'd0) begin
                                // Divide by zero: flag it, leave HI/LO alone.
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end else begin
                                op_d    = op;
                                a_neg_d = in_a_neg;
                                b_neg_d = in_b_neg;
                                a_mag_d = mag32(a, in_a_neg);
                                b_mag_d = mag32(b, in_b_neg);
                                rem_d   = 32'd0;
                                quo_d   = mag32(a, in_a_neg);
                                cnt_d   = 6'd0;
                                busy_d  = 1'b1;
                                state_d = S_DIV;
                            end
                        end
                        OP_MTHI: begin
                            hi_d   = a;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = a;
                            done_d = 1'b1;
                        end
                        default: begin
                            // Reserved encodings are ignored.
                        end
                    endcase
                end
            end

            S_MUL: begin
                // Add the multiplicand when the current multiplier bit is set,
                // then shift the whole accumulator right by one.
                acc_d = {mul_sum, acc_q[31:1]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end

            S_DIV: begin
                // Restoring step: keep the subtraction only if it does not go negative.
                if (div_fits) begin
                    rem_d = div_diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = div_part[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (fix_is_mul) begin
                    hi_d = fix_prod[63:32];
                    lo_d = fix_prod[31:0];
                end else begin
                    // Quotient sign follows the operand signs; remainder follows the dividend.
                    lo_d = (a_neg_q ^ b_neg_q) ? neg32(quo_q) : quo_q;
                    hi_d = a_neg_q ? neg32(rem_q) : rem_q;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register: asynchronous reset returns every flop to zero / IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            op_q    <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_mag_q <= 32'd0;
            b_mag_q <= 32'd0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            acc_q   <= 64'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_muldiv_sequencer;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected architectural HI/LO as tracked by the bench
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    // Reference model outputs for the operation being issued
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_dbz;
    logic        m_long;

    muldiv_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural model: plain 64-bit arithmetic on the operands.
    function automatic void ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] p;
        sx     = longint'($signed(x));
        sy     = longint'($signed(y));
        m_hi   = exp_hi;
        m_lo   = exp_lo;
        m_dbz  = 1'b0;
        m_long = 1'b0;
        case (o)
            OP_MULT: begin
                p = sx * sy;
                m_hi = p[63:32];
                m_lo = p[31:0];
                m_long = 1'b1;
            end
            OP_MULTU: begin
                p = {32'd0, x} * {32'd0, y};
                m_hi = p[63:32];
                m_lo = p[31:0];
                m_long = 1'b1;
            end
            OP_DIV: begin
                if (y == 32'd0) begin
                    m_dbz = 1'b1;
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    m_lo = 32'(q);
                    m_hi = 32'(r);
                    m_long = 1'b1;
                end
            end
            OP_DIVU: begin
                if (y == 32'd0) begin
                    m_dbz = 1'b1;
                end else begin
                    m_lo = x / y;
                    m_hi = x % y;
                    m_long = 1'b1;
                end
            end
            OP_MTHI: m_hi = x;
            OP_MTLO: m_lo = x;
            default: ;
        endcase
    endfunction

    // Issue one operation from a negedge and return at the negedge of its done cycle.
    task automatic do_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        int n;
        ref_model(o, av, bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
        n = 0;
        if (m_long) begin
            while (busy === 1'b1 && n < 60) begin
                check1("done_while_busy", done, 1'b0);
                check32("hi_stable_busy", hi, exp_hi);
                check32("lo_stable_busy", lo, exp_lo);
                if (n == 3) begin
                    start = 1'b1;
                    op    = OP_MTHI;
                    a     = $urandom;
                end else begin
                    start = 1'b0;
                end
                n++;
                @(negedge clk);
            end
            start = 1'b0;
            checkn("busy_cycles", n, 33);
        end
        check1("done_pulse", done, 1'b1);
        check1("busy_at_done", busy, 1'b0);
        check1("div_by_zero", div_by_zero, m_dbz);
        exp_hi = m_hi;
        exp_lo = m_lo;
        check32("hi_result", hi, exp_hi);
        check32("lo_result", lo, exp_lo);
    endtask

    // Idle cycles: nothing should pulse or move.
    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check1("idle_done", done, 1'b0);
            check1("idle_busy", busy, 1'b0);
            check1("idle_dbz", div_by_zero, 1'b0);
            check32("idle_hi", hi, exp_hi);
            check32("idle_lo", lo, exp_lo);
        end
    endtask

    // Reserved encodings must be ignored entirely.
    task automatic reserved_op(input logic [2:0] o);
        start = 1'b1;
        op    = o;
        a     = $urandom;
        b     = $urandom;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check1("rsvd_done", done, 1'b0);
        check1("rsvd_busy", busy, 1'b0);
        check32("rsvd_hi", hi, exp_hi);
        check32("rsvd_lo", lo, exp_lo);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        a      = 32'd0;
        b      = 32'd0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_dbz", div_by_zero, 1'b0);
        check32("rst_hi", hi, 32'd0);
        check32("rst_lo", lo, 32'd0);
        reset = 1'b0;
        idle(1);

        reserved_op(3'b110);
        reserved_op(3'b111);

        // Signed multiply with mixed signs
        do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        check32("mult_neg3x7_hi", hi, 32'hFFFF_FFFF);
        check32("mult_neg3x7_lo", lo, 32'hFFFF_FFEB);
        idle(2);

        // Unsigned multiply of maximum operands
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check32("multu_max_hi", hi, 32'hFFFF_FFFE);
        check32("multu_max_lo", lo, 32'h0000_0001);

        // Signed and unsigned divides, issued back-to-back
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check32("div_neg7_2_lo", lo, 32'hFFFF_FFFD);
        check32("div_neg7_2_hi", hi, 32'hFFFF_FFFF);
        do_op(OP_DIVU, 32'd7, 32'd2);
        check32("divu_7_2_lo", lo, 32'd3);
        check32("divu_7_2_hi", hi, 32'd1);
        idle(1);

        // Divide by zero leaves HI/LO as written by MTHI/MTLO
        do_op(OP_MTHI, 32'h0000_1234, 32'd0);
        do_op(OP_MTLO, 32'h0000_5678, 32'd0);
        do_op(OP_DIV, 32'h0000_0042, 32'd0);
        check32("dbz_hi", hi, 32'h0000_1234);
        check32("dbz_lo", lo, 32'h0000_5678);
        idle(2);

        // Overflowing divide issued in the done cycle of a multiply
        do_op(OP_MULT, 32'h1234_5678, 32'h8765_4321);
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check32("div_ovf_lo", lo, 32'h8000_0000);
        check32("div_ovf_hi", hi, 32'h0000_0000);
        idle(1);

        // Reset in the middle of a divide, with an ignored start pending
        start = 1'b1;
        op    = OP_DIV;
        a     = 32'd1000;
        b     = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULTU;
        a     = $urandom;
        b     = $urandom;
        check1("abort_busy_running", busy, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        check1("abort_busy", busy, 1'b0);
        check1("abort_done", done, 1'b0);
        check32("abort_hi", hi, 32'd0);
        check32("abort_lo", lo, 32'd0);
        @(negedge clk);
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check32("rst_start_ignored_hi", hi, 32'd0);
        check1("rst_start_ignored_done", done, 1'b0);
        reset = 1'b0;
        idle(40);
        do_op(OP_MTLO, 32'd1, 32'd0);
        check32("post_abort_lo", lo, 32'd1);
        check32("post_abort_hi", hi, 32'd0);

        // Random operations against the reference model
        for (int i = 0; i < 30; i++) begin
            r_op = 3'($urandom_range(0, 5));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 5))
                0: r_b = 32'd0;
                1: r_b = 32'($urandom_range(1, 9));
                2: r_a = 32'h8000_0000;
                3: r_b = 32'hFFFF_FFFF;
                default: ;
            endcase
            do_op(r_op, r_a, r_b);
            if ($urandom_range(0, 1) == 0) begin
                idle(1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
